// File: rtl/voice_pkg.sv
// Shared register map, CTRL/STATUS bit positions and FSM state types for the
// voice queue controller.
package voice_pkg;

   localparam logic [1:0] REG_PUSH   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_CLR    = 2'd3;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_FLUSH = 1;
   localparam int CTRL_IRQ   = 2;

   localparam int ST_OVF   = 15;
   localparam int ST_PLAY  = 14;
   localparam int ST_FULL  = 13;
   localparam int ST_EMPTY = 12;

   typedef enum logic {
      B_IDLE,
      B_ACK
   } bus_state_t;

   typedef enum logic [1:0] {
      P_IDLE,
      P_START,
      P_WAIT
   } play_state_t;

endpackage

// File: rtl/voice_fifo.sv
// Phoneme FIFO: pointers wrap modulo DEPTH; a push while full is accepted
// only when a pop happens in the same cycle.
module voice_fifo #(
   parameter int DEPTH = 16,
   parameter int PH_W  = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [PH_W-1:0]            wdata,
   output logic [PH_W-1:0]            rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [PH_W-1:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // storage needs no reset; pointers define what is valid
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/voice_queue_controller.sv
// 68000-bus register front end, phoneme FIFO and playback sequencer.
//  state   | meaning
//  B_IDLE  | waiting for select + AS_L low; access executes on leaving
//  B_ACK   | DTACK asserted, read data held until AS_L rises
//  P_IDLE  | waiting for enable, data and synthesizer not busy; pops head
//  P_START | one-cycle start pulse to the synthesizer
//  P_WAIT  | phoneme in flight until the finish pulse
module voice_queue_controller
   import voice_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int PH_W  = 8
) (
   input  logic             Clk,
   input  logic             Reset_L,
   input  logic             VoiceSelect_H,
   input  logic             AS_L,
   input  logic             LDS_L,
   input  logic             RW,
   input  logic [1:0]       RegAddr,
   input  logic [15:0]      DataIn,
   output logic [15:0]      DataOut,
   output logic             VoiceDtack_L,
   output logic [PH_W-1:0]  phoneme_sel,
   output logic             start_phoneme_output,
   input  logic             phoneme_speech_busy,
   input  logic             phoneme_speech_finish,
   output logic             Voice_IRQ_L
);

   localparam int CW = $clog2(DEPTH) + 1;

   bus_state_t  bus_state, bus_next;
   play_state_t play_state, play_next;

   logic            access;
   logic            wr_en;
   logic            push;
   logic            pop;
   logic            flush;
   logic            full;
   logic            empty;
   logic [CW-1:0]   count;
   logic [PH_W-1:0] head;
   logic            enable;
   logic            irq_en;
   logic            overflow;
   logic [15:0]     status;
   logic [15:0]     rd_data;
   logic [15:0]     data_q;
   logic            unused_bits;

   assign unused_bits = ^DataIn;

   assign access = (bus_state == B_IDLE) && VoiceSelect_H && !AS_L;
   assign wr_en  = access && !RW && !LDS_L;
   assign push   = wr_en && (RegAddr == REG_PUSH);
   assign flush  = wr_en && (RegAddr == REG_CTRL) && DataIn[CTRL_FLUSH];

   voice_fifo #(.DEPTH(DEPTH), .PH_W(PH_W)) u_fifo (
      .clk   (Clk),
      .rst_n (Reset_L),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata (DataIn[PH_W-1:0]),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_ff @(posedge Clk or negedge Reset_L) begin
      if (!Reset_L) begin
         bus_state  <= B_IDLE;
         play_state <= P_IDLE;
      end else begin
         bus_state  <= bus_next;
         play_state <= play_next;
      end
   end

   always_comb begin
      bus_next = bus_state;
      case (bus_state)
         B_IDLE:  if (VoiceSelect_H && !AS_L) bus_next = B_ACK;
         B_ACK:   if (AS_L) bus_next = B_IDLE;
         default: bus_next = B_IDLE;
      endcase
   end

   always_comb begin
      play_next = play_state;
      pop       = 1'b0;
      case (play_state)
         P_IDLE: begin
            if (enable && !empty && !phoneme_speech_busy) begin
               pop       = 1'b1;
               play_next = P_START;
            end
         end
         P_START: play_next = P_WAIT;
         P_WAIT:  if (phoneme_speech_finish) play_next = P_IDLE;
         default: play_next = P_IDLE;
      endcase
   end

   always_comb begin
      status           = '0;
      status[ST_OVF]   = overflow;
      status[ST_PLAY]  = (play_state != P_IDLE);
      status[ST_FULL]  = full;
      status[ST_EMPTY] = empty;
      status[8:0]      = 9'(count);
   end

   always_comb begin
      rd_data = '0;
      case (RegAddr)
         REG_STATUS: rd_data = status;
         REG_CTRL: begin
            rd_data[CTRL_EN]  = enable;
            rd_data[CTRL_IRQ] = irq_en;
         end
         default: rd_data = '0;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_L) begin
      if (!Reset_L) begin
         data_q      <= '0;
         enable      <= 1'b0;
         irq_en      <= 1'b0;
         overflow    <= 1'b0;
         phoneme_sel <= '0;
      end else begin
         if (access) data_q <= RW ? rd_data : 16'h0000;
         if (wr_en && (RegAddr == REG_CTRL)) begin
            enable <= DataIn[CTRL_EN];
            irq_en <= DataIn[CTRL_IRQ];
         end
         // a pop in the same cycle frees the slot, so only a pop-less push overflows
         if (wr_en && (RegAddr == REG_CLR)) overflow <= 1'b0;
         else if (push && full && !pop)     overflow <= 1'b1;
         if (pop) phoneme_sel <= head;
      end
   end

   assign VoiceDtack_L         = (bus_state != B_ACK);
   assign DataOut              = (bus_state == B_ACK) ? data_q : 16'h0000;
   assign start_phoneme_output = (play_state == P_START);
   assign Voice_IRQ_L          = !(irq_en && empty && (play_state == P_IDLE));

endmodule

// File: tb/tb_voice_queue_controller.sv
// Directed bench for voice_queue_controller: queue-level reference model
// compared every cycle, plus hand-computed register and pulse expectations.
module tb_voice_queue_controller;

   localparam int DEPTH = 16;
   localparam int PH_W  = 8;

   logic        Clk = 1'b0;
   logic        Reset_L = 1'b0;
   logic        VoiceSelect_H = 1'b0;
   logic        AS_L = 1'b1;
   logic        LDS_L = 1'b1;
   logic        RW = 1'b1;
   logic [1:0]  RegAddr = 2'd0;
   logic [15:0] DataIn = 16'h0;
   logic [15:0] DataOut;
   logic        VoiceDtack_L;
   logic [7:0]  phoneme_sel;
   logic        start_phoneme_output;
   logic        phoneme_speech_busy = 1'b0;
   logic        phoneme_speech_finish = 1'b0;
   logic        Voice_IRQ_L;

   int passed = 0;
   int total  = 0;

   always #5 Clk = ~Clk;

   voice_queue_controller #(.DEPTH(DEPTH), .PH_W(PH_W)) dut (
      .Clk                   (Clk),
      .Reset_L               (Reset_L),
      .VoiceSelect_H         (VoiceSelect_H),
      .AS_L                  (AS_L),
      .LDS_L                 (LDS_L),
      .RW                    (RW),
      .RegAddr               (RegAddr),
      .DataIn                (DataIn),
      .DataOut               (DataOut),
      .VoiceDtack_L          (VoiceDtack_L),
      .phoneme_sel           (phoneme_sel),
      .start_phoneme_output  (start_phoneme_output),
      .phoneme_speech_busy   (phoneme_speech_busy),
      .phoneme_speech_finish (phoneme_speech_finish),
      .Voice_IRQ_L           (Voice_IRQ_L)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // reference model: bus handshake, a queue of codes and a phoneme phase
   logic [7:0]  q[$];
   logic        m_ack, m_en, m_irq, m_ovf;
   logic [15:0] m_data;
   logic [7:0]  m_sel;
   int          m_ph;   // 0 nothing in flight, 1 start cycle, 2 speaking
   logic        m_acc, m_wr, m_pop;
   logic [15:0] m_st;

   always @(posedge Clk or negedge Reset_L) begin
      if (!Reset_L) begin
         q.delete();
         m_ack = 0; m_en = 0; m_irq = 0; m_ovf = 0;
         m_data = 0; m_sel = 0; m_ph = 0;
      end else begin
         m_acc = !m_ack && VoiceSelect_H && !AS_L;
         m_wr  = m_acc && !RW && !LDS_L;
         m_pop = (m_ph == 0) && m_en && (q.size() != 0) && !phoneme_speech_busy;
         m_st  = {m_ovf, m_ph != 0, q.size() == DEPTH, q.size() == 0, 3'b000, 9'(q.size())};
         if (m_acc) begin
            if (!RW) m_data = 16'h0;
            else if (RegAddr == 2'd1) m_data = m_st;
            else if (RegAddr == 2'd2) m_data = {13'h0, m_irq, 1'b0, m_en};
            else m_data = 16'h0;
            m_ack = 1;
         end else if (m_ack && AS_L) m_ack = 0;
         if (m_pop) begin
            m_sel = q.pop_front();
            m_ph = 1;
         end else if (m_ph == 1) m_ph = 2;
         else if (m_ph == 2 && phoneme_speech_finish) m_ph = 0;
         if (m_wr) begin
            case (RegAddr)
               2'd0: if (q.size() < DEPTH) q.push_back(DataIn[7:0]); else m_ovf = 1;
               2'd2: begin
                  m_en = DataIn[0];
                  m_irq = DataIn[2];
                  if (DataIn[1]) q.delete();
               end
               2'd3: m_ovf = 0;
               default: ;
            endcase
         end
      end
   end

   always @(negedge Clk) begin
      check("cycle_outputs",
            {5'b0, VoiceDtack_L, DataOut, phoneme_sel, start_phoneme_output, Voice_IRQ_L},
            {5'b0, !m_ack, (m_ack ? m_data : 16'h0), m_sel, m_ph == 1,
             !(m_irq && q.size() == 0 && m_ph == 0)});
   end

   task automatic bus_cycle(input logic [1:0] a, input logic rw_i, input logic [15:0] d,
                            input logic lds_i, input logic rel_busy, output logic [15:0] rd);
      @(negedge Clk);
      VoiceSelect_H = 1; AS_L = 0; RW = rw_i; LDS_L = lds_i; RegAddr = a; DataIn = d;
      if (rel_busy) phoneme_speech_busy = 0;
      @(negedge Clk);
      check("dtack_assert", {31'b0, VoiceDtack_L}, 32'd0);
      rd = DataOut;
      if (rel_busy) phoneme_speech_busy = 1;
      AS_L = 1; VoiceSelect_H = 0; LDS_L = 1;
      @(negedge Clk);
      check("dtack_release", {31'b0, VoiceDtack_L}, 32'd1);
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      logic [15:0] dummy;
      bus_cycle(a, 1'b0, d, 1'b0, 1'b0, dummy);
   endtask

   task automatic rd_check(input string name, input logic [1:0] a, input logic [15:0] exp);
      logic [15:0] v;
      bus_cycle(a, 1'b1, 16'h0, 1'b0, 1'b0, v);
      check(name, {16'h0, v}, {16'h0, exp});
   endtask

   task automatic wait_start(input string name, input logic [7:0] exp_sel);
      int n = 0;
      while (start_phoneme_output !== 1'b1 && n < 40) begin
         @(negedge Clk);
         n++;
      end
      check({name, "_start_seen"}, {31'b0, start_phoneme_output}, 32'd1);
      check({name, "_sel"}, {24'h0, phoneme_sel}, {24'h0, exp_sel});
   endtask

   task automatic finish_pulse();
      @(negedge Clk);
      phoneme_speech_finish = 1;
      @(negedge Clk);
      phoneme_speech_finish = 0;
   endtask

   logic [15:0] tmp;

   initial begin
      repeat (3) @(negedge Clk);
      check("reset_outputs",
            {5'b0, VoiceDtack_L, DataOut, phoneme_sel, start_phoneme_output, Voice_IRQ_L},
            {5'b0, 1'b1, 16'h0, 8'h00, 1'b0, 1'b1});
      Reset_L = 1;
      rd_check("status_after_reset", 2'd1, 16'h1000);

      // queue three codes while disabled, then play
      wr(2'd0, 16'h0011);
      wr(2'd0, 16'h0022);
      wr(2'd0, 16'h0033);
      rd_check("status_count3", 2'd1, 16'h0003);
      wr(2'd2, 16'h0001);
      wait_start("first", 8'h11);
      phoneme_speech_busy = 1;
      finish_pulse();
      repeat (4) @(negedge Clk);
      rd_check("no_pop_while_busy", 2'd1, 16'h0002);
      phoneme_speech_busy = 0;
      wait_start("second", 8'h22);
      wr(2'd2, 16'h0000);
      finish_pulse();
      repeat (5) @(negedge Clk);
      rd_check("disable_stops_pops", 2'd1, 16'h0001);
      wr(2'd2, 16'h0002);
      rd_check("flush_to_empty", 2'd1, 16'h1000);
      rd_check("ctrl_flush_reads0", 2'd2, 16'h0000);

      // overflow on the 17th push
      for (int i = 0; i < 17; i++) wr(2'd0, 16'h0040 + 16'(i));
      rd_check("status_overflow", 2'd1, 16'hA010);
      wr(2'd3, 16'h0000);
      rd_check("overflow_cleared", 2'd1, 16'h2010);
      bus_cycle(2'd0, 1'b0, 16'h0099, 1'b1, 1'b0, tmp);
      rd_check("lds_high_no_effect", 2'd1, 16'h2010);

      // push coinciding with the pop of a full FIFO
      phoneme_speech_busy = 1;
      wr(2'd2, 16'h0001);
      bus_cycle(2'd0, 1'b0, 16'h0077, 1'b0, 1'b1, tmp);
      check("coincide_sel", {24'h0, phoneme_sel}, 32'h40);
      rd_check("coincide_status", 2'd1, 16'h6010);
      wr(2'd2, 16'h0003);
      rd_check("flush_in_flight", 2'd1, 16'h5000);
      phoneme_speech_busy = 0;
      finish_pulse();
      rd_check("flushed_idle", 2'd1, 16'h1000);

      // drain interrupt
      wr(2'd2, 16'h0004);
      check("irq_empty_idle", {31'b0, Voice_IRQ_L}, 32'd0);
      wr(2'd0, 16'h0001);
      check("irq_cleared_by_push", {31'b0, Voice_IRQ_L}, 32'd1);
      wr(2'd0, 16'h0002);
      wr(2'd2, 16'h0005);
      wait_start("irq_first", 8'h01);
      finish_pulse();
      wait_start("irq_second", 8'h02);
      check("irq_high_before_last_finish", {31'b0, Voice_IRQ_L}, 32'd1);
      finish_pulse();
      check("irq_after_last_finish", {31'b0, Voice_IRQ_L}, 32'd0);
      wr(2'd0, 16'h0003);
      check("irq_raised_by_push", {31'b0, Voice_IRQ_L}, 32'd1);
      wait_start("irq_third", 8'h03);
      finish_pulse();
      wr(2'd2, 16'h0000);

      // reset in the middle of a bus cycle
      @(negedge Clk);
      VoiceSelect_H = 1; AS_L = 0; RW = 1; LDS_L = 0; RegAddr = 2'd1;
      @(negedge Clk);
      check("midcycle_ack", {31'b0, VoiceDtack_L}, 32'd0);
      #2 Reset_L = 0;
      #1 check("reset_drops_dtack", {15'b0, VoiceDtack_L, DataOut}, {15'b0, 1'b1, 16'h0});
      AS_L = 1; VoiceSelect_H = 0; LDS_L = 1;
      @(negedge Clk);
      Reset_L = 1;
      @(negedge Clk);
      check("no_ack_after_release", {31'b0, VoiceDtack_L}, 32'd1);
      rd_check("ctrl_after_reset", 2'd2, 16'h0000);
      rd_check("status_after_midreset", 2'd1, 16'h1000);

      @(negedge Clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1);
   end

endmodule
